// File: rtl/dec_pkg.sv
// Shared types and constants for the N-by-M sequencing decoder.
// Optional error-pulse logic in dec_nxm_seq is enabled by defining DEC_ERR_EN.
package dec_pkg;

  // Operating state, derived every cycle from en/mode.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Disabled block is always IDLE; otherwise mode picks the behaviour.
  function automatic dec_state_e dec_state_of(input logic en, input logic mode);
    if (!en)                return IDLE;
    else if (mode == MODE_DIRECT) return DIRECT;
    else                    return SCAN;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W -> NOUT one-hot decoder; an index at or beyond NOUT
// decodes to all zeros since no output line matches it.
module dec_onehot #(
  parameter int SEL_W = 3,
  parameter int NOUT  = 8
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [NOUT-1:0]  oh_o
);

  genvar g;
  generate
    for (g = 0; g < NOUT; g++) begin : g_line
      assign oh_o[g] = (sel_i == SEL_W'(g));
    end
  endgenerate

endmodule

// File: rtl/dec_nxm_seq.sv
// Registered line decoder with direct-load and auto-scan modes.
// Define DEC_ERR_EN to add the err port, a one-cycle pulse after any
// enabled load whose index is out of range.
module dec_nxm_seq
  import dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int NOUT  = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [SEL_W-1:0] bin,
  output logic [NOUT-1:0]  d,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
`ifdef DEC_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(NOUT - 1);
  localparam logic [SEL_W:0]    NOUT_X   = (SEL_W + 1)'(NOUT);

  dec_state_e        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NOUT-1:0]   d_q, d_d;
  logic              wrap_q, wrap_d;
  logic [NOUT-1:0]   oh;
  logic              bin_ok, ld_ok;
  logic              d_clr, d_dec;

  // Extra MSB keeps the range check correct when NOUT == 2**SEL_W.
  assign bin_ok = ({1'b0, bin} < NOUT_X);
  assign ld_ok  = load & bin_ok;

  // The output pattern always follows the next index, so one decoder serves
  // loads, scan steps and scan entry alike.
  dec_onehot #(.SEL_W(SEL_W), .NOUT(NOUT)) u_onehot (
    .sel_i (idx_d),
    .oh_o  (oh)
  );

  // State register; state_q remembers whether we were already scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state is a pure function of the current en/mode.
  always_comb begin
    state_d = IDLE;
    state_d = dec_state_of(en, mode);
  end

  // Index, dwell counter and wrap next-state per operating state.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = '0;
    wrap_d = 1'b0;
    d_clr  = 1'b0;
    d_dec  = 1'b0;
    case (state_d)
      DIRECT: begin
        if (load) begin
          if (bin_ok) begin
            idx_d = bin;
            d_dec = 1'b1;
          end else begin
            d_clr = 1'b1;
          end
        end
      end
      SCAN: begin
        d_dec = 1'b1;
        if (ld_ok) begin
          // A valid load beats dwell expiry and restarts the dwell.
          idx_d = bin;
        end else if (state_q == SCAN) begin
          if (cnt_q == CNT_LAST) begin
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // First scan cycle: show the held index with a fresh dwell.
      end
      default: d_clr = 1'b1;
    endcase
  end

  // Output pattern select: clear, decode the next index, or hold.
  always_comb begin
    d_d = d_q;
    if (d_clr)      d_d = '0;
    else if (d_dec) d_d = oh;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      d_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      wrap_q <= wrap_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

`ifdef DEC_ERR_EN
  logic err_q;

  // Flag any enabled load that names a nonexistent line, in either mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= en & load & ~bin_ok;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_dec_nxm_seq.sv
// Bench for dec_nxm_seq: two instances (8 lines/dwell 4 and 6 lines/dwell 3)
// share stimulus and are checked against a line-level reference model.
module tb_dec_nxm_seq;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [2:0] bin;
  logic [7:0] d8;
  logic [2:0] idx8;
  logic       wrap8;
  logic [5:0] d6;
  logic [2:0] idx6;
  logic       wrap6;
`ifdef DEC_ERR_EN
  logic       err8, err6;
`endif

  always #5 clk = ~clk;

  dec_nxm_seq #(.SEL_W(3), .NOUT(8), .DWELL(4)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .bin(bin),
    .d(d8), .idx(idx8), .wrap(wrap8)
`ifdef DEC_ERR_EN
    , .err(err8)
`endif
  );

  dec_nxm_seq #(.SEL_W(3), .NOUT(6), .DWELL(3)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .bin(bin),
    .d(d6), .idx(idx6), .wrap(wrap6)
`ifdef DEC_ERR_EN
    , .err(err6)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one entry per instance. m_line is the lit line, -1 = none.
  int m_nout [2] = '{8, 6};
  int m_dwell[2] = '{4, 3};
  int m_idx [2];
  int m_line[2];
  int m_cnt [2];
  bit m_wrap[2];
  bit m_err [2];
  bit m_scan[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_d(input int m);
    return (m_line[m] < 0) ? 32'd0 : (32'd1 << m_line[m]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_idx[m] = 0; m_line[m] = -1; m_cnt[m] = 0;
      m_wrap[m] = 0; m_err[m] = 0; m_scan[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit ok;
      ok        = int'(bin) < m_nout[m];
      m_err[m]  = en && load && !ok;
      m_wrap[m] = 0;
      if (!en) begin
        m_line[m] = -1; m_cnt[m] = 0; m_scan[m] = 0;
      end else if (!mode) begin
        m_cnt[m] = 0; m_scan[m] = 0;
        if (load) begin
          if (ok) begin m_idx[m] = int'(bin); m_line[m] = int'(bin); end
          else m_line[m] = -1;
        end
      end else begin
        if (load && ok) begin
          m_idx[m] = int'(bin); m_line[m] = int'(bin); m_cnt[m] = 0;
        end else if (!m_scan[m]) begin
          m_line[m] = m_idx[m]; m_cnt[m] = 0;
        end else if (m_cnt[m] == m_dwell[m] - 1) begin
          m_cnt[m] = 0;
          if (m_idx[m] == m_nout[m] - 1) begin m_idx[m] = 0; m_wrap[m] = 1; end
          else m_idx[m] = m_idx[m] + 1;
          m_line[m] = m_idx[m];
        end else begin
          m_cnt[m] = m_cnt[m] + 1;
        end
        m_scan[m] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/d8"},    d8,    exp_d(0));
    chk({tag, "/idx8"},  idx8,  m_idx[0]);
    chk({tag, "/wrap8"}, wrap8, m_wrap[0]);
    chk({tag, "/d6"},    d6,    exp_d(1));
    chk({tag, "/idx6"},  idx6,  m_idx[1]);
    chk({tag, "/wrap6"}, wrap6, m_wrap[1]);
`ifdef DEC_ERR_EN
    chk({tag, "/err8"},  err8,  m_err[0]);
    chk({tag, "/err6"},  err6,  m_err[1]);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, k, held;
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; bin = '0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // Direct load and hold
    en = 1'b1; mode = 1'b0; load = 1'b1; bin = 3'd3;
    step("direct_ld3");
    chk("ld3_d8", d8, 8'b0000_1000);
    chk("ld3_idx8", idx8, 3);
    load = 1'b0;
    step("direct_hold");
    step("direct_hold2");
    chk("hold_d8", d8, 8'b0000_1000);

    // Out-of-range for the 6-line instance
    load = 1'b1; bin = 3'd7;
    step("direct_ld7");
    chk("ld7_d6", d6, 6'b0);
    chk("ld7_idx6", idx6, 3);
    chk("ld7_d8", d8, 8'b1000_0000);
    load = 1'b0;
    step("after_ld7");

    // Scan from idx 0: one advance every 4 cycles, one wrap in 40 cycles
    load = 1'b1; bin = 3'd0;
    step("direct_ld0");
    load = 1'b0; mode = 1'b1;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      step("scan");
      if (wrap8 === 1'b1) begin
        nw++;
        chk("wrap_d8", d8, 8'b0000_0001);
      end
      if (i == 3) chk("scan_dwell_idx8", idx8, 0);
      if (i == 4) chk("scan_adv_idx8", idx8, 1);
    end
    chk("wrap8_pulses", nw, 1);

    // Load on the dwell-expiry cycle at idx 4
    k = 0;
    while (!(m_idx[0] == 4 && m_cnt[0] == 3) && k < 100) begin
      step("seek4"); k++;
    end
    chk("seek4_reached", 32'(k < 100), 1);
    load = 1'b1; bin = 3'd2;
    step("scan_ld2");
    chk("ld2_idx8", idx8, 2);
    chk("ld2_d8", d8, 8'b0000_0100);
    chk("ld2_wrap8", wrap8, 0);
    load = 1'b0;

    // Disable during scan, then resume from the held index
    step("scan_run");
    en = 1'b0;
    step("idle");
    chk("idle_d8", d8, 8'b0);
    held = m_idx[0];
    step("idle2");
    en = 1'b1; mode = 1'b1;
    step("resume");
    chk("resume_d8", d8, 32'd1 << held);
    for (int i = 0; i < 6; i++) step("resume_run");

    // Asynchronous reset mid-scan at idx 5
    k = 0;
    while (m_idx[0] != 5 && k < 100) begin
      step("seek5"); k++;
    end
    chk("seek5_reached", 32'(k < 100), 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_d8", d8, 8'b0);
    chk("arst_idx8", idx8, 0);
    chk("arst_wrap8", wrap8, 0);
    chk("arst_d6", d6, 6'b0);
    @(posedge clk); #1;
    check_all("in_reset");
    rst = 1'b0;
    step("post_rst");
    chk("post_rst_d8", d8, 8'b0000_0001);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      load = ($urandom_range(0, 5) == 0);
      bin  = 3'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
